// File: rtl/hack_data_mem_if.sv
// CPU data bus (M bus) plus the video scanner's screen read port.
// The master is the bus driver and the slave is the memory.
interface hack_data_mem_if;
    logic [14:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] inM;
    logic        vid_req;
    logic [12:0] vid_addr;
    logic [15:0] vid_data;
    logic        vid_valid;

    modport master (
        output addressM, outM, writeM, vid_req, vid_addr,
        input  inM, vid_data, vid_valid
    );

    modport slave (
        input  addressM, outM, writeM, vid_req, vid_addr,
        output inM, vid_data, vid_valid
    );
endinterface

// File: rtl/hack_data_mem.sv
// Hack data memory: RAM, screen buffer and keyboard register on the CPU M bus,
// with a registered second read port into the screen for the video scanner.
module hack_data_mem #(
    parameter int unsigned RAM_AW   = 14,
    parameter int unsigned SCR_AW   = 13,
    parameter logic [14:0] KBD_ADDR = 15'h6000
) (
    input  logic              clk_cpu,
    input  logic              rst,
    hack_data_mem_if.slave    m,
    input  logic [15:0]       kbd_code,
    input  logic              kbd_strobe,
    output logic              bad_wr
);
    localparam int unsigned RAM_DEPTH = 32'd1 << RAM_AW;
    localparam int unsigned SCR_DEPTH = 32'd1 << SCR_AW;
    localparam logic [14:0] SCR_BASE  = 15'(RAM_DEPTH);
    localparam logic [14:0] SCR_END   = 15'(RAM_DEPTH + SCR_DEPTH - 1);

    logic [15:0] ram_mem [RAM_DEPTH];
    logic [15:0] scr_mem [SCR_DEPTH];

    logic        ram_sel, scr_sel, kbd_sel;
    logic        ram_we, scr_we;
    logic [15:0] kbd_d, kbd_q;
    logic [15:0] vid_data_d, vid_data_q;
    logic        vid_valid_d, vid_valid_q;
    logic        bad_wr_d, bad_wr_q;

    // Address decode, CPU read mux and next-state for all control flops.
    always_comb begin
        ram_sel     = (m.addressM < SCR_BASE);
        scr_sel     = (m.addressM >= SCR_BASE) && (m.addressM <= SCR_END);
        kbd_sel     = (m.addressM == KBD_ADDR);
        ram_we      = m.writeM && ram_sel && !rst;
        scr_we      = m.writeM && scr_sel && !rst;
        kbd_d       = kbd_strobe ? kbd_code : kbd_q;
        vid_valid_d = m.vid_req;
        vid_data_d  = m.vid_req ? scr_mem[m.vid_addr[SCR_AW-1:0]] : vid_data_q;
        bad_wr_d    = bad_wr_q || (m.writeM && !ram_sel && !scr_sel);
        m.inM       = 16'h0000;
        if (ram_sel) begin
            m.inM = ram_mem[m.addressM[RAM_AW-1:0]];
        end else if (scr_sel) begin
            m.inM = scr_mem[m.addressM[SCR_AW-1:0]];
        end else if (kbd_sel) begin
            m.inM = kbd_q;
        end
    end

    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            kbd_q       <= 16'h0000;
            vid_data_q  <= 16'h0000;
            vid_valid_q <= 1'b0;
            bad_wr_q    <= 1'b0;
        end else begin
            kbd_q       <= kbd_d;
            vid_data_q  <= vid_data_d;
            vid_valid_q <= vid_valid_d;
            bad_wr_q    <= bad_wr_d;
        end
    end

    // Storage is never cleared; video reads see the pre-write word on a collision.
    always_ff @(posedge clk_cpu) begin
        if (ram_we) begin
            ram_mem[m.addressM[RAM_AW-1:0]] <= m.outM;
        end
        if (scr_we) begin
            scr_mem[m.addressM[SCR_AW-1:0]] <= m.outM;
        end
    end

    assign m.vid_data  = vid_data_q;
    assign m.vid_valid = vid_valid_q;
    assign bad_wr      = bad_wr_q;
endmodule

// File: tb/tb_hack_data_mem.sv
// Directed vector bench for hack_data_mem: one table row per clock cycle.
module tb_hack_data_mem;
    logic        clk_cpu = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] kbd_code = 16'h0;
    logic        kbd_strobe = 1'b0;
    logic        bad_wr;

    hack_data_mem_if bus();

    hack_data_mem dut (
        .clk_cpu    (clk_cpu),
        .rst        (rst),
        .m          (bus),
        .kbd_code   (kbd_code),
        .kbd_strobe (kbd_strobe),
        .bad_wr     (bad_wr)
    );

    always #5 clk_cpu = ~clk_cpu;

    typedef struct {
        logic        r;
        logic        we;
        logic [14:0] a;
        logic [15:0] d;
        logic        ks;
        logic [15:0] kc;
        logic        vr;
        logic [12:0] va;
        logic        ci;   // check inM before the edge
        logic [15:0] ei;
        logic        cv;   // check video outputs after the edge
        logic        evv;
        logic [15:0] evd;
        logic        eb;   // bad_wr after the edge, always checked
    } vec_t;

    vec_t tbl[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    function automatic vec_t mk(logic r, logic we, logic [14:0] a, logic [15:0] d,
                                logic ks, logic [15:0] kc, logic vr, logic [12:0] va,
                                logic ci, logic [15:0] ei, logic cv, logic evv,
                                logic [15:0] evd, logic eb);
        vec_t v;
        v.r = r; v.we = we; v.a = a; v.d = d; v.ks = ks; v.kc = kc;
        v.vr = vr; v.va = va; v.ci = ci; v.ei = ei; v.cv = cv;
        v.evv = evv; v.evd = evd; v.eb = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk_cpu);
        rst          = v.r;
        bus.writeM   = v.we;
        bus.addressM = v.a;
        bus.outM     = v.d;
        kbd_strobe   = v.ks;
        kbd_code     = v.kc;
        bus.vid_req  = v.vr;
        bus.vid_addr = v.va;
        #1;
        if (v.ci) check({tag, " inM"}, bus.inM, v.ei);
        @(posedge clk_cpu);
        #1;
        if (v.cv) begin
            check({tag, " vid_valid"}, 16'(bus.vid_valid), 16'(v.evv));
            check({tag, " vid_data"}, bus.vid_data, v.evd);
        end
        check({tag, " bad_wr"}, 16'(bad_wr), 16'(v.eb));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.writeM = 1'b0; bus.addressM = 15'h0; bus.outM = 16'h0;
        bus.vid_req = 1'b0; bus.vid_addr = 13'h0;

        //              r  we a        d        ks kc       vr va     ci ei       cv vv vd       eb
        tbl.push_back(mk(1, 0, 15'h0000, 16'h0000, 0, 16'h0000, 0, 13'h0, 0, 16'h0000, 1, 0, 16'h0000, 0));
        // RAM / screen round trip and the 0x3FFF/0x4000 boundary
        tbl.push_back(mk(0, 1, 15'h0000, 16'h3039, 0, 16'h0000, 0, 13'h0, 0, 16'h0000, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 15'h0000, 16'h0000, 0, 16'h0000, 0, 13'h0, 1, 16'h3039, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 1, 15'h3FFF, 16'hFFFF, 0, 16'h0000, 0, 13'h0, 0, 16'h0000, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 15'h3FFF, 16'h0000, 0, 16'h0000, 0, 13'h0, 1, 16'hFFFF, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 1, 15'h4000, 16'h1234, 0, 16'h0000, 0, 13'h0, 0, 16'h0000, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 15'h4000, 16'h0000, 0, 16'h0000, 0, 13'h0, 1, 16'h1234, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 15'h3FFF, 16'h0000, 0, 16'h0000, 0, 13'h0, 1, 16'hFFFF, 0, 0, 16'h0000, 0));
        // same-cycle write shows the old value
        tbl.push_back(mk(0, 1, 15'h0005, 16'h0001, 0, 16'h0000, 0, 13'h0, 0, 16'h0000, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 1, 15'h0005, 16'h0002, 0, 16'h0000, 0, 13'h0, 1, 16'h0001, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 15'h0005, 16'h0000, 0, 16'h0000, 0, 13'h0, 1, 16'h0002, 0, 0, 16'h0000, 0));
        // keyboard: strobe/read same cycle returns old value, release code 0, illegal write
        tbl.push_back(mk(0, 0, 15'h6000, 16'h0000, 1, 16'h0041, 0, 13'h0, 1, 16'h0000, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 15'h6000, 16'h0000, 0, 16'h0000, 0, 13'h0, 1, 16'h0041, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 15'h6000, 16'h0000, 1, 16'h0000, 0, 13'h0, 1, 16'h0041, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 15'h6000, 16'h0000, 0, 16'h0000, 0, 13'h0, 1, 16'h0000, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 1, 15'h6000, 16'h00FF, 0, 16'h0000, 0, 13'h0, 1, 16'h0000, 0, 0, 16'h0000, 1));
        tbl.push_back(mk(0, 0, 15'h6000, 16'h0000, 0, 16'h0000, 0, 13'h0, 1, 16'h0000, 0, 0, 16'h0000, 1));
        tbl.push_back(mk(0, 0, 15'h6000, 16'h0000, 1, 16'h0077, 0, 13'h0, 0, 16'h0000, 0, 0, 16'h0000, 1));
        tbl.push_back(mk(1, 0, 15'h6000, 16'h0000, 0, 16'h0000, 0, 13'h0, 1, 16'h0077, 1, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 15'h6000, 16'h0000, 0, 16'h0000, 0, 13'h0, 1, 16'h0000, 0, 0, 16'h0000, 0));
        // unmapped space and the 0x5FFF/0x6000 boundary
        tbl.push_back(mk(0, 1, 15'h1FFF, 16'h1111, 0, 16'h0000, 0, 13'h0, 0, 16'h0000, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 1, 15'h5FFF, 16'h2222, 0, 16'h0000, 0, 13'h0, 0, 16'h0000, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 15'h6001, 16'h0000, 0, 16'h0000, 0, 13'h0, 1, 16'h0000, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 15'h7FFF, 16'h0000, 0, 16'h0000, 0, 13'h0, 1, 16'h0000, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 1, 15'h7FFF, 16'hBEEF, 0, 16'h0000, 0, 13'h0, 0, 16'h0000, 0, 0, 16'h0000, 1));
        tbl.push_back(mk(0, 0, 15'h1FFF, 16'h0000, 0, 16'h0000, 0, 13'h0, 1, 16'h1111, 0, 0, 16'h0000, 1));
        tbl.push_back(mk(0, 0, 15'h5FFF, 16'h0000, 0, 16'h0000, 0, 13'h0, 1, 16'h2222, 0, 0, 16'h0000, 1));
        // video burst of four words
        tbl.push_back(mk(0, 1, 15'h4000, 16'hA000, 0, 16'h0000, 0, 13'h0, 0, 16'h0000, 0, 0, 16'h0000, 1));
        tbl.push_back(mk(0, 1, 15'h4001, 16'hA001, 0, 16'h0000, 0, 13'h0, 0, 16'h0000, 0, 0, 16'h0000, 1));
        tbl.push_back(mk(0, 1, 15'h4002, 16'hA002, 0, 16'h0000, 0, 13'h0, 0, 16'h0000, 0, 0, 16'h0000, 1));
        tbl.push_back(mk(0, 1, 15'h4003, 16'hA003, 0, 16'h0000, 0, 13'h0, 0, 16'h0000, 0, 0, 16'h0000, 1));
        tbl.push_back(mk(0, 0, 15'h0000, 16'h0000, 0, 16'h0000, 1, 13'h0, 0, 16'h0000, 1, 1, 16'hA000, 1));
        tbl.push_back(mk(0, 0, 15'h0000, 16'h0000, 0, 16'h0000, 1, 13'h1, 0, 16'h0000, 1, 1, 16'hA001, 1));
        tbl.push_back(mk(0, 0, 15'h0000, 16'h0000, 0, 16'h0000, 1, 13'h2, 0, 16'h0000, 1, 1, 16'hA002, 1));
        tbl.push_back(mk(0, 0, 15'h0000, 16'h0000, 0, 16'h0000, 1, 13'h3, 0, 16'h0000, 1, 1, 16'hA003, 1));
        tbl.push_back(mk(0, 0, 15'h0000, 16'h0000, 0, 16'h0000, 0, 13'h0, 0, 16'h0000, 1, 0, 16'hA003, 1));
        // collision: video gets the pre-write word, CPU write still lands
        tbl.push_back(mk(0, 1, 15'h4007, 16'h5555, 0, 16'h0000, 0, 13'h0, 0, 16'h0000, 0, 0, 16'h0000, 1));
        tbl.push_back(mk(0, 1, 15'h4007, 16'hAAAA, 0, 16'h0000, 1, 13'h7, 1, 16'h5555, 1, 1, 16'h5555, 1));
        tbl.push_back(mk(0, 0, 15'h4007, 16'h0000, 0, 16'h0000, 1, 13'h7, 1, 16'hAAAA, 1, 1, 16'hAAAA, 1));
        // reset with a pending write and video request
        tbl.push_back(mk(1, 1, 15'h0000, 16'hDEAD, 0, 16'h0000, 1, 13'h7, 1, 16'h3039, 1, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 15'h0000, 16'h0000, 0, 16'h0000, 0, 13'h0, 1, 16'h3039, 1, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 15'h0005, 16'h0000, 0, 16'h0000, 0, 13'h0, 1, 16'h0002, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 15'h3FFF, 16'h0000, 0, 16'h0000, 0, 13'h0, 1, 16'hFFFF, 0, 0, 16'h0000, 0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

        // Screen write under reset is discarded; video held at zero until reset drops.
        apply(mk(1, 1, 15'h4007, 16'h1111, 0, 16'h0000, 1, 13'h7, 0, 16'h0000, 1, 0, 16'h0000, 0), "seq_a0");
        apply(mk(0, 0, 15'h4007, 16'h0000, 0, 16'h0000, 1, 13'h7, 1, 16'hAAAA, 1, 1, 16'hAAAA, 0), "seq_a1");
        apply(mk(0, 0, 15'h4003, 16'h0000, 0, 16'h0000, 1, 13'h3, 1, 16'hA003, 1, 1, 16'hA003, 0), "seq_a2");
        apply(mk(0, 0, 15'h4003, 16'h0000, 0, 16'h0000, 0, 13'h0, 0, 16'h0000, 1, 0, 16'hA003, 0), "seq_a3");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
